// File: rtl/heater_err_monitor.sv
// Error monitor for an array of bram_delay heater lanes: sequences err_clear after startup, then records errors.
// Latency: one cycle from lane_error sample to err_sticky/err_count/fault/first_* update; all outputs registered.
// Backpressure: none; lane_error is sampled every cycle. Optional macro HEATER_ERR_TIMESTAMP_EN adds first_time.
module heater_err_monitor #(
  parameter int N_LANES        = 8,
  parameter int WARMUP_CYCLES  = 4160,
  parameter int HOLDOFF_CYCLES = 32,
  parameter int CNT_W          = 16,
  localparam int LANE_W        = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_sw_clear,
  input  logic [N_LANES-1:0] i_lane_error,
  output logic               o_lane_err_clear,
  output logic               o_armed,
  output logic               o_fault,
  output logic [N_LANES-1:0] o_err_sticky,
  output logic [CNT_W-1:0]   o_err_count,
  output logic               o_first_valid,
  output logic [LANE_W-1:0]  o_first_lane
`ifdef HEATER_ERR_TIMESTAMP_EN
  ,
  output logic [31:0]        o_first_time
`endif
);

  // Timer only ever holds a load value of (cycles - 1), so size it for the larger of the two.
  localparam int TMR_MAX = (WARMUP_CYCLES > HOLDOFF_CYCLES) ? WARMUP_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] WARM_LOAD = TMR_W'(WARMUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

  localparam int POP_W = $clog2(N_LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WARMUP  = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_HOLDOFF = 3'd3;
  localparam logic [2:0] S_ARMED   = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]         r_state;
  logic [TMR_W-1:0]   r_timer;
  logic               r_lane_err_clear;
  logic               r_armed;
  logic               r_fault;
  logic [N_LANES-1:0] r_err_sticky;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_first_valid;
  logic [LANE_W-1:0]  r_first_lane;

  logic [2:0]         w_state_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               w_any_err;
  logic               w_rec;
  logic               w_clr;
  logic [POP_W-1:0]   w_pop;
  logic [LANE_W-1:0]  w_low;
  logic [SUM_W-1:0]   w_sum;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_any_err = |i_lane_error;

  // Next-state and timer: enable=0 wins over sw_clear, which wins over lane_error.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WARMUP;
          w_timer_nxt = WARM_LOAD;
        end
        S_WARMUP: begin
          if (r_timer == '0) w_state_nxt = S_CLEAR;
          else               w_timer_nxt = r_timer - TMR_W'(1);
        end
        S_CLEAR: begin
          w_state_nxt = S_HOLDOFF;
          w_timer_nxt = HOLD_LOAD;
        end
        S_HOLDOFF: begin
          if (i_sw_clear)          w_state_nxt = S_CLEAR;
          else if (r_timer == '0)  w_state_nxt = S_ARMED;
          else                     w_timer_nxt = r_timer - TMR_W'(1);
        end
        S_ARMED: begin
          if (i_sw_clear)     w_state_nxt = S_CLEAR;
          else if (w_any_err) w_state_nxt = S_FAULT;
        end
        S_FAULT: begin
          if (i_sw_clear) w_state_nxt = S_CLEAR;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Stats are zeroed on the edge entering CLEAR so they already read zero during the CLEAR cycle.
  assign w_clr = (w_state_nxt == S_CLEAR);
  // Record only while armed and the cycle is not being pre-empted by enable=0 or an accepted sw_clear.
  assign w_rec = ((r_state == S_ARMED) || (r_state == S_FAULT)) && i_enable && !i_sw_clear && w_any_err;

  // Population count and lowest set lane index of the current error vector.
  always_comb begin
    w_pop = '0;
    w_low = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_pop = w_pop + POP_W'(i_lane_error[i]);
    end
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (i_lane_error[i]) w_low = LANE_W'(i);
    end
  end

  // Saturating add: any carry into the upper bits pins the count at all-ones.
  always_comb begin
    w_sum     = SUM_W'(r_err_count) + SUM_W'(w_pop);
    w_cnt_nxt = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // State, timer and the state-decoded outputs, registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_timer          <= '0;
      r_lane_err_clear <= 1'b1;
      r_armed          <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_timer          <= w_timer_nxt;
      r_lane_err_clear <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WARMUP) ||
                          (w_state_nxt == S_CLEAR);
      r_armed          <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_FAULT);
    end
  end

  // Error statistics: cleared entering CLEAR, accumulated while recording, retained otherwise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fault       <= 1'b0;
      r_err_sticky  <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_lane  <= '0;
    end else if (w_clr) begin
      r_fault       <= 1'b0;
      r_err_sticky  <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_lane  <= '0;
    end else if (w_rec) begin
      r_fault      <= 1'b1;
      r_err_sticky <= r_err_sticky | i_lane_error;
      r_err_count  <= w_cnt_nxt;
      if (!r_first_valid) begin
        r_first_valid <= 1'b1;
        r_first_lane  <= w_low;
      end
    end
  end

`ifdef HEATER_ERR_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_first_time;

  // Free-running cycle counter, zeroed with the stats; first_time latches it alongside first_lane.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ts         <= '0;
      r_first_time <= '0;
    end else begin
      r_ts <= w_clr ? 32'd0 : r_ts + 32'd1;
      if (w_clr)                        r_first_time <= '0;
      else if (w_rec && !r_first_valid) r_first_time <= r_ts;
    end
  end

  assign o_first_time = r_first_time;
`endif

  assign o_lane_err_clear = r_lane_err_clear;
  assign o_armed          = r_armed;
  assign o_fault          = r_fault;
  assign o_err_sticky     = r_err_sticky;
  assign o_err_count      = r_err_count;
  assign o_first_valid    = r_first_valid;
  assign o_first_lane     = r_first_lane;

endmodule

// File: tb/tb_heater_err_monitor.sv
// Directed bench for heater_err_monitor with short warmup/holdoff and a 4-bit counter.
// Table rows apply one cycle of inputs and check all outputs after the edge.
// Hand-written sequences cover warmup/holdoff timing, re-arming and asynchronous reset.
module tb_heater_err_monitor;

  localparam int NL = 8;
  localparam int WU = 20;
  localparam int HO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sw_clear;
  logic [NL-1:0] lane_error;
  logic          lane_err_clear;
  logic          armed;
  logic          fault;
  logic [NL-1:0] err_sticky;
  logic [CW-1:0] err_count;
  logic          first_valid;
  logic [2:0]    first_lane;
`ifdef HEATER_ERR_TIMESTAMP_EN
  logic [31:0]   first_time;
`endif

  int n_checks = 0;
  int n_errors = 0;

  heater_err_monitor #(
    .N_LANES(NL), .WARMUP_CYCLES(WU), .HOLDOFF_CYCLES(HO), .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_enable(enable),
    .i_sw_clear(sw_clear),
    .i_lane_error(lane_error),
    .o_lane_err_clear(lane_err_clear),
    .o_armed(armed),
    .o_fault(fault),
    .o_err_sticky(err_sticky),
    .o_err_count(err_count),
    .o_first_valid(first_valid),
    .o_first_lane(first_lane)
`ifdef HEATER_ERR_TIMESTAMP_EN
    ,
    .o_first_time(first_time)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          sc;
    logic [NL-1:0] le;
    logic          clr;
    logic          arm;
    logic          flt;
    logic [NL-1:0] stk;
    logic [CW-1:0] cnt;
    logic          fv;
    logic [2:0]    fl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input int i);
    chk($sformatf("row%0d_clear", i), 32'(lane_err_clear), 32'(vecs[i].clr));
    chk($sformatf("row%0d_armed", i), 32'(armed),          32'(vecs[i].arm));
    chk($sformatf("row%0d_fault", i), 32'(fault),          32'(vecs[i].flt));
    chk($sformatf("row%0d_sticky", i), 32'(err_sticky),    32'(vecs[i].stk));
    chk($sformatf("row%0d_count", i), 32'(err_count),      32'(vecs[i].cnt));
    chk($sformatf("row%0d_fvalid", i), 32'(first_valid),   32'(vecs[i].fv));
    chk($sformatf("row%0d_flane", i), 32'(first_lane),     32'(vecs[i].fl));
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      enable     = vecs[i].en;
      sw_clear   = vecs[i].sc;
      lane_error = vecs[i].le;
      step();
      check_row(i);
    end
  endtask

  initial begin
    int n;
    //          en    sc    le      clr   arm   flt   stk     cnt    fv    fl
    // Starting in ARMED with clean stats.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'h24, 1'b0, 1'b1, 1'b1, 8'h24, 4'd2,  1'b1, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h24, 4'd2,  1'b1, 3'd2};
    vecs[3]  = '{1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd4,  1'b1, 3'd2};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd12, 1'b1, 3'd2};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd15, 1'b1, 3'd2};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd15, 1'b1, 3'd2};
    // sw_clear with a simultaneous error: CLEAR, error discarded.
    vecs[7]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0,  1'b0, 3'd0};
    // Re-armed: new first error, then enable=0 (with sw_clear and error) -> IDLE, stats kept.
    vecs[8]  = '{1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 4'd1,  1'b1, 3'd4};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 4'd1,  1'b1, 3'd4};
    vecs[10] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h10, 4'd1,  1'b1, 3'd4};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 4'd1,  1'b1, 3'd4};
    // Back to WARMUP: errors ignored, stats still retained.
    vecs[12] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h10, 4'd1,  1'b1, 3'd4};

    reset      = 1'b1;
    enable     = 1'b0;
    sw_clear   = 1'b0;
    lane_error = '0;
    #12;
    chk("rst_clear",  32'(lane_err_clear), 32'd1);
    chk("rst_armed",  32'(armed),          32'd0);
    chk("rst_fault",  32'(fault),          32'd0);
    chk("rst_sticky", 32'(err_sticky),     32'd0);
    chk("rst_count",  32'(err_count),      32'd0);
    chk("rst_fvalid", 32'(first_valid),    32'd0);
    chk("rst_flane",  32'(first_lane),     32'd0);

    // Startup with errors present throughout warmup and holdoff.
    step();
    reset      = 1'b0;
    enable     = 1'b1;
    lane_error = 8'hFF;
    n = 0;
    while (lane_err_clear && n < 1000) begin
      step();
      n++;
    end
    // clear stays high for WU+1 edges, so it is first seen low after edge WU+2.
    chk("warmup_edges", 32'(n), 32'(WU + 2));
    n = 0;
    while (!armed && n < 1000) begin
      chk("holdoff_clear_low", 32'(lane_err_clear), 32'd0);
      step();
      n++;
    end
    chk("holdoff_edges", 32'(n), 32'(HO));
    lane_error = '0;
    chk("armed_fault",  32'(fault),       32'd0);
    chk("armed_sticky", 32'(err_sticky),  32'd0);
    chk("armed_count",  32'(err_count),   32'd0);
    chk("armed_fvalid", 32'(first_valid), 32'd0);

    apply_rows(0, 7);

    // From CLEAR: one edge into HOLDOFF, then HO edges until ARMED.
    sw_clear   = 1'b0;
    lane_error = '0;
    n = 0;
    while (!armed && n < 1000) begin
      step();
      n++;
    end
    chk("rearm_edges", 32'(n), 32'(HO + 1));
    chk("rearm_fault", 32'(fault), 32'd0);
    chk("rearm_count", 32'(err_count), 32'd0);

    apply_rows(8, 12);

    // Asynchronous reset mid-WARMUP clears everything without a clock edge.
    #3;
    reset = 1'b1;
    #1;
    chk("arst_clear",  32'(lane_err_clear), 32'd1);
    chk("arst_fault",  32'(fault),          32'd0);
    chk("arst_sticky", 32'(err_sticky),     32'd0);
    chk("arst_count",  32'(err_count),      32'd0);
    chk("arst_fvalid", 32'(first_valid),    32'd0);
    step();
    chk("arst_hold_clear", 32'(lane_err_clear), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
